mem_arbiter: RTL

//  Shares the single-port 8-bit x 8192 unified memory between two requesters:
//  - instruction fetch (IF) port: read-only
//  - data (D) port: read/write

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: widths and types shared by the unified-memory arbiter.
// Round-robin tie-breaking is built when MEM_ARB_RR_EN is defined.
package mem_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {PORT_IF, PORT_D} arb_port_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between IF and D requests.
// MEM_ARB_RR_EN: ties go to the port not served last; otherwise D always wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic      if_req_i,
  input  logic      d_req_i,
`ifdef MEM_ARB_RR_EN
  input  arb_port_t last_i,
`endif
  output logic      valid_o,
  output arb_port_t port_o
);
  assign valid_o = if_req_i | d_req_i;
`ifdef MEM_ARB_RR_EN
  always_comb port_o = (if_req_i & d_req_i) ? (last_i == PORT_IF ? PORT_D : PORT_IF)
                                            : (d_req_i ? PORT_D : PORT_IF);
`else
  always_comb port_o = d_req_i ? PORT_D : PORT_IF;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 8x8192 memory between an IF read port and a D read/write port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed D-over-IF priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  arb_state_t        state_q;
  arb_port_t         port_q;
  mem_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              if_gnt_q, d_gnt_q, if_done_q, d_done_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              pick_valid, access, last_beat;
  arb_port_t         pick_port;
`ifdef MEM_ARB_RR_EN
  arb_port_t         last_q;
`endif
  arb_pick u_pick (
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
`ifdef MEM_ARB_RR_EN
    .last_i   (last_q),
`endif
    .valid_o  (pick_valid),
    .port_o   (pick_port)
  );
  // IF is read-only, so its latched request never carries write data
  always_comb req_d = pick_port == PORT_D ? mem_req_t'{addr: d_addr_i, we: d_we_i, wdata: d_wdata_i}
                                          : mem_req_t'{addr: if_addr_i, we: 1'b0, wdata: '0};
  assign access      = state_q == ARB_ACCESS;
  assign last_beat   = cnt_q == '0;
  assign mem_addr_o  = access ? req_q.addr : '0;
  assign mem_rd_o    = access & ~req_q.we;
  assign mem_wr_o    = access & req_q.we & last_beat;
  assign mem_wdata_o = (access & req_q.we) ? req_q.wdata : '0;
  assign if_gnt_o    = if_gnt_q;
  assign d_gnt_o     = d_gnt_q;
  assign if_done_o   = if_done_q;
  assign d_done_o    = d_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      port_q     <= PORT_IF;
      req_q      <= '0;
      cnt_q      <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= PORT_IF;
`endif
    end else begin
      if_gnt_q  <= 1'b0;
      d_gnt_q   <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: if (pick_valid) begin
          state_q  <= ARB_ACCESS;
          port_q   <= pick_port;
          req_q    <= req_d;
          cnt_q    <= CNT_W'(MEM_LAT - 1);
          if_gnt_q <= pick_port == PORT_IF;
          d_gnt_q  <= pick_port == PORT_D;
`ifdef MEM_ARB_RR_EN
          last_q   <= pick_port;
`endif
        end
        ARB_ACCESS: if (!last_beat) cnt_q <= cnt_q - 1'b1;
        else begin
          state_q   <= ARB_DONE;
          if_done_q <= port_q == PORT_IF;
          d_done_q  <= port_q == PORT_D;
          if (!req_q.we && port_q == PORT_IF) if_rdata_q <= mem_rdata_i;
          if (!req_q.we && port_q == PORT_D) d_rdata_q <= mem_rdata_i;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
endmodule
